gpi_pad_ctrl: RTL and testbench
===============================

# gpi_pad_ctrl

Configuration and input-conditioning controller for a bank of N GPI input pad cells (1.8 V EG GPI type). Holds per-pad control state that drives each pad's IE/STE/PU/PD pins and sequences input-enable settling. Synchronizes and debounces each pad's DI_O[0] into the core clock domain. Also runs an on-demand float-detect probe that toggles the pad pulls to flag unconnected pins.

## Interface
- N_PADS, 8, number of pads controlled
- SYNC_STAGES, 2, synchronizer flops on pad data (min 2)
- DEB_W, 8, debounce length counter width
- SETTLE_W, 6, settle counter width

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  write strobe for one pad's config
- cfg_idx  in  $clog2(N_PADS)  pad index; indices ≥ N_PADS are ignored
- cfg_wdata  in  5  {ie, ste[1:0], pull[1:0]}; pull: 00 none, 01 down, 10 up, 11 keeper
- deb_len  in  DEB_W  debounce length, static while any pad is enabled
- settle_len  in  SETTLE_W  IE settle time, static during use
- probe_start  in  1  start float probe (pulse)
- probe_busy  out  1  probe in progress
- probe_done  out  1  one-cycle pulse at probe end
- float_o  out  N_PADS  per-pad float flag from last probe
- pad_ie_o  out  N_PADS  to pad IE_I
- pad_ste_o  out  2*N_PADS  to pad STE_I, pad k at [2k+1:2k]
- pad_pu_o / pad_pd_o  out  N_PADS each  to pad PU_I / PD_I
- pad_di_i  in  N_PADS  from pad DI_O[0], asynchronous
- din_o  out  N_PADS  debounced level
- din_valid_o  out  N_PADS  pad settled, din_o meaningful
- rise_o / fall_o  out  N_PADS each  one-cycle edge pulses of din_o

## Operation
- Config regs reset to ie=0, ste=00, pull=01 (pull-down). Pull map: 00→pu=0,pd=0; 01→0,1; 10→1,0; 11→1,1 (pad keeper).
- Reset values: all outputs 0 except pad_pd_o all 1.
- Write takes effect on the clk edge that samples cfg_we.
  - An ie 0→1 write clears din_valid_o and loads the settle counter with settle_len.
  - An ie 1→0 write clears din_valid_o, din_o and the debounce state immediately.
- din_valid_o[k] rises settle_len+SYNC_STAGES+1 cycles after the enabling write edge.
  - While not valid, the debounce state is loaded with the synchronized value; no edge pulses are produced.
- Debounce, per valid pad, with s = synchronized value, d = din_o and counter c:
  - If s==d: c←0.
  - Else if c==deb_len: d←s, c←0, and pulse rise_o or fall_o in the same cycle d changes.
  - Else: c←c+1.
  - A change therefore appears deb_len+1 cycles after s first differs from d.
- Probe FSM states IDLE→PU_PH→PD_PH→RESTORE→IDLE. Phase length W = settle_len+SYNC_STAGES+1 cycles.
  - IDLE: probe_start enters PU_PH on the next edge. probe_start is ignored when not in IDLE.
  - PU_PH: all pads forced ie=1, pu=1, pd=0; ste stays as configured. The synchronized value is sampled into hi[] in the last cycle of the phase.
  - PD_PH: forced ie=1, pu=0, pd=1. Sampled into lo[] in the last cycle.
  - RESTORE: one cycle. float_o ← hi & ~lo, probe_done=1, pad outputs return to config, and every ie=1 pad restarts its settle.
  - probe_busy is high in PU_PH, PD_PH and RESTORE: 2W+1 cycles total.
- During probe: din_valid_o=0 and din_o holds its value. Config writes update the registers but reach the pads only at RESTORE. float_o holds its old value until RESTORE.
- A cfg_we to a pad and a settle expiry on the same cycle: the write wins and settle restarts.
- rst asserted mid-probe or mid-settle: immediate return to reset values; float_o is cleared.

## Timing
- Pad control outputs are registered: 1-cycle latency from cfg write or FSM transition. No combinational path from any input to any output.
- pad_di_i enters the first synchronizer flop only; it is used nowhere else.
- Edge pulses coincide with the din_o change cycle. probe_done coincides with the float_o update.

## Test plan
- Reset, then read all outputs: pad_pd_o=8'hFF, everything else 0, probe_busy=0.
- Write pad 3 ie=1, pull=10, settle_len=4: pad_ie_o[3]=1 and pad_pu_o[3]=1 next cycle; din_valid_o[3] rises exactly 7 cycles after the write edge.
- deb_len=3, valid pad with din=0: a 2-cycle high glitch produces no change; a held high gives din_o=1 and rise_o a single pulse 4 cycles after the synchronized rise; release gives fall_o similarly.
- Probe with settle_len=2 (W=5), pad 0 floating (follows pulls), pad 1 tied high, pad 2 tied low: probe_busy is high for 11 cycles; float_o=3'b001 on pads 0–2; probe_done is a single pulse; second probe_start mid-probe is ignored.
- Config write to pad 5 during PD_PH: pad outputs unchanged until RESTORE, then they show the new config and settle restarts.
- Assert rst during PU_PH: all outputs return to reset values asynchronously; FSM is IDLE after release.

Source files
------------

// File: rtl/gpi_pad_ctrl.sv
// -----------------------------------------------------------------------------
// gpi_pad_ctrl
//
// Configuration and input-conditioning controller for a bank of GPI input pads.
// Holds per-pad IE/STE/pull configuration and drives the pad control pins from
// registers. It also sequences the input-enable settle time, synchronizes and
// debounces each pad's data input, and runs an on-demand float-detect probe.
// The probe drives every pad pulled up and then pulled down. A pad that reads
// high under pull-up and low under pull-down is flagged as floating.
//
// Ports
//   clk, rst            core clock, asynchronous active-high reset
//   cfg_we/idx/wdata    single-pad config write, wdata = {ie, ste[1:0], pull[1:0]}
//                       pull: 00 none, 01 down, 10 up, 11 keeper
//   deb_len             debounce length (cycles of disagreement minus one)
//   settle_len          IE settle time, also sets the probe phase length
//   probe_start         pulse: start a float probe (accepted only when idle)
//   probe_busy          probe in progress
//   probe_done          one-cycle pulse, coincides with the float_o update
//   float_o             per-pad float flag from the last completed probe
//   pad_ie_o/ste_o/pu_o/pd_o   registered pad control pins (ste: pad k at [2k+1:2k])
//   pad_di_i            asynchronous pad data, goes only into the synchronizer
//   din_o               debounced level
//   din_valid_o         pad settled, din_o meaningful
//   rise_o / fall_o     one-cycle pulses on din_o edges
//   dbg_probe_state     current probe FSM state (0 idle, 1 pull-up phase,
//                       2 pull-down phase, 3 restore)
//
// Handshake: cfg_we is a single-cycle strobe with no back-pressure. Every write
// is accepted on the edge that samples it. probe_start is a strobe honoured only
// in the idle state. probe_busy stays high until after the probe_done cycle.
// -----------------------------------------------------------------------------
module gpi_pad_ctrl #(
    parameter int N_PADS      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 8,
    parameter int SETTLE_W    = 6,
    localparam int IDX_W      = (N_PADS > 1) ? $clog2(N_PADS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [4:0]            cfg_wdata,
    input  logic [DEB_W-1:0]      deb_len,
    input  logic [SETTLE_W-1:0]   settle_len,
    input  logic                  probe_start,
    output logic                  probe_busy,
    output logic                  probe_done,
    output logic [N_PADS-1:0]     float_o,
    output logic [N_PADS-1:0]     pad_ie_o,
    output logic [2*N_PADS-1:0]   pad_ste_o,
    output logic [N_PADS-1:0]     pad_pu_o,
    output logic [N_PADS-1:0]     pad_pd_o,
    input  logic [N_PADS-1:0]     pad_di_i,
    output logic [N_PADS-1:0]     din_o,
    output logic [N_PADS-1:0]     din_valid_o,
    output logic [N_PADS-1:0]     rise_o,
    output logic [N_PADS-1:0]     fall_o,
    output logic [1:0]            dbg_probe_state
);

    // Wide enough to hold settle_len + SYNC_STAGES without wrapping.
    localparam int CNT_W = SETTLE_W + 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PU_PH   = 2'd1,
        ST_PD_PH   = 2'd2,
        ST_RESTORE = 2'd3
    } probe_state_t;

    // ------------------------------------------------------------------
    // Shared timing: a settle and a probe phase both span
    // settle_len + SYNC_STAGES + 1 cycles. A down-counter loaded with
    // settle_len + SYNC_STAGES and finishing on the edge where it reads
    // zero gives exactly that span.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] span_load;
    assign span_load = CNT_W'(settle_len) + CNT_W'(SYNC_STAGES);

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic [N_PADS-1:0]       cfg_ie_q,   cfg_ie_d;
    logic [N_PADS-1:0][1:0]  cfg_ste_q,  cfg_ste_d;
    logic [N_PADS-1:0][1:0]  cfg_pull_q, cfg_pull_d;
    logic [N_PADS-1:0]       wr_hit;

    always_comb begin
        cfg_ie_d   = cfg_ie_q;
        cfg_ste_d  = cfg_ste_q;
        cfg_pull_d = cfg_pull_q;
        wr_hit     = '0;
        for (int k = 0; k < N_PADS; k++) begin
            // Out-of-range indices never match any k, so they are ignored.
            if (cfg_we && (cfg_idx == IDX_W'(k))) begin
                wr_hit[k]     = 1'b1;
                cfg_ie_d[k]   = cfg_wdata[4];
                cfg_ste_d[k]  = cfg_wdata[3:2];
                cfg_pull_d[k] = cfg_wdata[1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_ie_q   <= '0;
            cfg_ste_q  <= '0;
            cfg_pull_q <= {N_PADS{2'b01}};
        end else begin
            cfg_ie_q   <= cfg_ie_d;
            cfg_ste_q  <= cfg_ste_d;
            cfg_pull_q <= cfg_pull_d;
        end
    end

    // ------------------------------------------------------------------
    // Pad data synchronizer: pad_di_i touches only the first stage.
    // ------------------------------------------------------------------
    logic [N_PADS-1:0] sync_q [SYNC_STAGES];
    logic [N_PADS-1:0] sync_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pad_di_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Float-probe FSM
    // ------------------------------------------------------------------
    probe_state_t      state_q, state_nxt;
    logic [CNT_W-1:0]  pcnt_q, pcnt_d;
    logic              sample_hi, sample_lo;
    logic [N_PADS-1:0] hi_q;

    always_comb begin
        state_nxt = state_q;
        pcnt_d    = pcnt_q;
        sample_hi = 1'b0;
        sample_lo = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (probe_start) begin
                    state_nxt = ST_PU_PH;
                    pcnt_d    = span_load;
                end
            end
            ST_PU_PH: begin
                if (pcnt_q == '0) begin
                    sample_hi = 1'b1;
                    state_nxt = ST_PD_PH;
                    pcnt_d    = span_load;
                end else begin
                    pcnt_d = pcnt_q - 1'b1;
                end
            end
            ST_PD_PH: begin
                if (pcnt_q == '0) begin
                    sample_lo = 1'b1;
                    state_nxt = ST_RESTORE;
                end else begin
                    pcnt_d = pcnt_q - 1'b1;
                end
            end
            ST_RESTORE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pcnt_q     <= '0;
            hi_q       <= '0;
            float_o    <= '0;
            probe_done <= 1'b0;
            probe_busy <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            pcnt_q     <= pcnt_d;
            if (sample_hi) hi_q <= sync_val;
            // The pull-down sample is used directly on the edge that ends the
            // phase, so float_o and probe_done land in the restore cycle.
            if (sample_lo) float_o <= hi_q & ~sync_val;
            probe_done <= sample_lo;
            probe_busy <= (state_nxt != ST_IDLE);
        end
    end

    assign dbg_probe_state = state_q;

    // ------------------------------------------------------------------
    // Registered pad drive. The next-state values are registered so that a
    // write or FSM transition shows on the pins one cycle later. During the
    // probe phases, config writes stay in the registers and are not driven.
    // ------------------------------------------------------------------
    logic [N_PADS-1:0]   ie_d, pu_d, pd_d;
    logic [2*N_PADS-1:0] ste_d;

    always_comb begin
        ie_d  = cfg_ie_d;
        pu_d  = '0;
        pd_d  = '0;
        ste_d = '0;
        for (int k = 0; k < N_PADS; k++) begin
            ste_d[2*k +: 2] = cfg_ste_d[k];
            pu_d[k]         = cfg_pull_d[k][1];
            pd_d[k]         = cfg_pull_d[k][0];
        end
        if (state_nxt == ST_PU_PH) begin
            ie_d  = '1;
            pu_d  = '1;
            pd_d  = '0;
            ste_d = pad_ste_o;
        end else if (state_nxt == ST_PD_PH) begin
            ie_d  = '1;
            pu_d  = '0;
            pd_d  = '1;
            ste_d = pad_ste_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_ie_o  <= '0;
            pad_ste_o <= '0;
            pad_pu_o  <= '0;
            pad_pd_o  <= '1;
        end else begin
            pad_ie_o  <= ie_d;
            pad_ste_o <= ste_d;
            pad_pu_o  <= pu_d;
            pad_pd_o  <= pd_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-pad settle and debounce
    // ------------------------------------------------------------------
    logic              probe_hold;
    logic [N_PADS-1:0] settling_q, settling_d;
    logic [CNT_W-1:0]  scnt_q [N_PADS];
    logic [CNT_W-1:0]  scnt_d [N_PADS];
    logic [DEB_W-1:0]  dcnt_q [N_PADS];
    logic [DEB_W-1:0]  dcnt_d [N_PADS];
    logic [N_PADS-1:0] valid_d, din_d, rise_d, fall_d;

    // Edges on which the pads are (or are about to be) driven by the probe.
    assign probe_hold = ((state_q == ST_IDLE) && probe_start) ||
                        (state_q == ST_PU_PH) || (state_q == ST_PD_PH);

    always_comb begin
        settling_d = settling_q;
        scnt_d     = scnt_q;
        dcnt_d     = dcnt_q;
        valid_d    = din_valid_o;
        din_d      = din_o;
        rise_d     = '0;
        fall_d     = '0;
        for (int k = 0; k < N_PADS; k++) begin
            if (sample_lo) begin
                // Entering restore: enabled pads settle again from scratch.
                valid_d[k]   = 1'b0;
                dcnt_d[k]    = '0;
                settling_d[k] = cfg_ie_d[k];
                scnt_d[k]    = span_load;
                if (!cfg_ie_d[k]) din_d[k] = 1'b0;
            end else if (probe_hold) begin
                // din_o holds its value while the probe owns the pads.
                valid_d[k] = 1'b0;
                dcnt_d[k]  = '0;
            end else if (wr_hit[k] && !cfg_wdata[4]) begin
                settling_d[k] = 1'b0;
                valid_d[k]    = 1'b0;
                din_d[k]      = 1'b0;
                dcnt_d[k]     = '0;
            end else if (wr_hit[k] && (!cfg_ie_q[k] || settling_q[k])) begin
                // Enabling write, or a rewrite during settle: the write wins
                // over a settle expiring on the same edge.
                settling_d[k] = 1'b1;
                scnt_d[k]     = span_load;
                valid_d[k]    = 1'b0;
                din_d[k]      = sync_val[k];
                dcnt_d[k]     = '0;
            end else if (din_valid_o[k]) begin
                if (sync_val[k] == din_o[k]) begin
                    dcnt_d[k] = '0;
                end else if (dcnt_q[k] == deb_len) begin
                    din_d[k]  = sync_val[k];
                    dcnt_d[k] = '0;
                    rise_d[k] = sync_val[k];
                    fall_d[k] = ~sync_val[k];
                end else begin
                    dcnt_d[k] = dcnt_q[k] + 1'b1;
                end
            end else if (settling_q[k]) begin
                // Not yet valid: track the input so no edge fires on release.
                din_d[k]  = sync_val[k];
                dcnt_d[k] = '0;
                if (scnt_q[k] == '0) begin
                    settling_d[k] = 1'b0;
                    valid_d[k]    = 1'b1;
                end else begin
                    scnt_d[k] = scnt_q[k] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settling_q  <= '0;
            din_valid_o <= '0;
            din_o       <= '0;
            rise_o      <= '0;
            fall_o      <= '0;
            for (int k = 0; k < N_PADS; k++) begin
                scnt_q[k] <= '0;
                dcnt_q[k] <= '0;
            end
        end else begin
            settling_q  <= settling_d;
            din_valid_o <= valid_d;
            din_o       <= din_d;
            rise_o      <= rise_d;
            fall_o      <= fall_d;
            scnt_q      <= scnt_d;
            dcnt_q      <= dcnt_d;
        end
    end

endmodule

// File: tb/tb_gpi_pad_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpi_pad_ctrl
//
// Directed bench for gpi_pad_ctrl: reset values, config write and settle timing,
// debounce glitch/edge behaviour, float probe, config write during a probe, and
// reset asserted mid-probe. Pad 0 models an unconnected pin that follows the
// pad pulls. All other pads are driven from pad_ext.
// -----------------------------------------------------------------------------
module tb_gpi_pad_ctrl;
  localparam int N_PADS      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int DEB_W       = 8;
  localparam int SETTLE_W    = 6;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                cfg_we;
  logic [2:0]          cfg_idx;
  logic [4:0]          cfg_wdata;
  logic [DEB_W-1:0]    deb_len;
  logic [SETTLE_W-1:0] settle_len;
  logic                probe_start;
  logic                probe_busy;
  logic                probe_done;
  logic [7:0]          float_o;
  logic [7:0]          pad_ie_o;
  logic [15:0]         pad_ste_o;
  logic [7:0]          pad_pu_o;
  logic [7:0]          pad_pd_o;
  wire  [7:0]          pad_di;
  logic [7:0]          din_o;
  logic [7:0]          din_valid_o;
  logic [7:0]          rise_o;
  logic [7:0]          fall_o;
  logic [1:0]          dbg_probe_state;

  logic [7:0] pad_ext;
  // pad 0 floats: high only when pulled up and not pulled down
  assign pad_di = {pad_ext[7:1], pad_pu_o[0] & ~pad_pd_o[0]};

  gpi_pad_ctrl #(
    .N_PADS      (N_PADS),
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_W       (DEB_W),
    .SETTLE_W    (SETTLE_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_we          (cfg_we),
    .cfg_idx         (cfg_idx),
    .cfg_wdata       (cfg_wdata),
    .deb_len         (deb_len),
    .settle_len      (settle_len),
    .probe_start     (probe_start),
    .probe_busy      (probe_busy),
    .probe_done      (probe_done),
    .float_o         (float_o),
    .pad_ie_o        (pad_ie_o),
    .pad_ste_o       (pad_ste_o),
    .pad_pu_o        (pad_pu_o),
    .pad_pd_o        (pad_pd_o),
    .pad_di_i        (pad_di),
    .din_o           (din_o),
    .din_valid_o     (din_valid_o),
    .rise_o          (rise_o),
    .fall_o          (fall_o),
    .dbg_probe_state (dbg_probe_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int busy_cnt     = 0;
  int done_cnt     = 0;
  int rise_cnt     = 0;
  int fall_cnt     = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // advance one clock; sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (probe_busy === 1'b1) busy_cnt++;
    if (probe_done === 1'b1) done_cnt++;
    if (rise_o != 8'h00) rise_cnt++;
    if (fall_o != 8'h00) fall_cnt++;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [4:0] data);
    cfg_we    = 1'b1;
    cfg_idx   = idx;
    cfg_wdata = data;
    tick();
    cfg_we    = 1'b0;
  endtask

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    cfg_we      = 1'b0;
    cfg_idx     = '0;
    cfg_wdata   = '0;
    deb_len     = 8'd3;
    settle_len  = 6'd4;
    probe_start = 1'b0;
    pad_ext     = 8'h00;

    // ---------------- reset values ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_pd",    16'(pad_pd_o), 16'h00FF);
    check("rst_ie",    16'(pad_ie_o), 16'h0000);
    check("rst_pu",    16'(pad_pu_o), 16'h0000);
    check("rst_ste",   pad_ste_o,     16'h0000);
    check("rst_din",   16'(din_o),    16'h0000);
    check("rst_valid", 16'(din_valid_o), 16'h0000);
    check("rst_edges", 16'({rise_o, fall_o}), 16'h0000);
    check("rst_float", 16'(float_o),  16'h0000);
    check("rst_busy",  16'(probe_busy), 16'h0000);
    check("rst_done",  16'(probe_done), 16'h0000);
    check("rst_state", 16'(dbg_probe_state), 16'h0000);
    rst = 1'b0;
    tick();
    tick();

    // ---------------- config write + settle (settle_len=4) ----------------
    cfg_write(3'd3, 5'b10010);              // ie=1, ste=00, pull=up
    check("wr_ie",  16'(pad_ie_o), 16'h0008);
    check("wr_pu",  16'(pad_pu_o), 16'h0008);
    check("wr_pd",  16'(pad_pd_o), 16'h00F7);
    repeat (6) tick();
    check("settle_e6", 16'(din_valid_o), 16'h0000);
    tick();
    check("settle_e7", 16'(din_valid_o), 16'h0008);
    check("settle_din", 16'(din_o), 16'h0000);

    // ---------------- debounce (deb_len=3) ----------------
    rise_cnt = 0;
    fall_cnt = 0;
    pad_ext = 8'h08;                         // 2-cycle glitch after sync
    tick();
    tick();
    pad_ext = 8'h00;
    repeat (8) tick();
    check("glitch_din",  16'(din_o), 16'h0000);
    check("glitch_rise", 16'(rise_cnt), 16'h0000);

    pad_ext = 8'h08;                         // held high
    repeat (5) tick();
    check("hold_h5_din", 16'(din_o), 16'h0000);
    tick();
    check("hold_h6_din",  16'(din_o),  16'h0008);
    check("hold_h6_rise", 16'(rise_o), 16'h0008);
    check("hold_h6_fall", 16'(fall_o), 16'h0000);
    tick();
    check("hold_h7_rise", 16'(rise_o), 16'h0000);
    check("rise_count",   16'(rise_cnt), 16'h0001);

    pad_ext = 8'h00;                         // release
    repeat (5) tick();
    check("rel_f5_din", 16'(din_o), 16'h0008);
    tick();
    check("rel_f6_din",  16'(din_o),  16'h0000);
    check("rel_f6_fall", 16'(fall_o), 16'h0008);
    tick();
    check("rel_f7_fall", 16'(fall_o), 16'h0000);
    check("fall_count",  16'(fall_cnt), 16'h0001);

    // ---------------- float probe (settle_len=2, W=5) ----------------
    settle_len = 6'd2;
    pad_ext    = 8'h02;                      // pad 1 tied high, pad 2 low
    repeat (3) tick();
    busy_cnt = 0;
    done_cnt = 0;
    probe_start = 1'b1;
    tick();                                  // P0
    probe_start = 1'b0;
    check("p0_busy",  16'(probe_busy), 16'h0001);
    check("p0_ie",    16'(pad_ie_o), 16'h00FF);
    check("p0_pu",    16'(pad_pu_o), 16'h00FF);
    check("p0_pd",    16'(pad_pd_o), 16'h0000);
    check("p0_state", 16'(dbg_probe_state), 16'h0001);
    check("p0_valid", 16'(din_valid_o), 16'h0000);
    repeat (4) tick();                       // P1..P4
    check("p4_pu", 16'(pad_pu_o), 16'h00FF);
    probe_start = 1'b1;                      // must be ignored
    tick();                                  // P5
    probe_start = 1'b0;
    check("p5_pu",    16'(pad_pu_o), 16'h0000);
    check("p5_pd",    16'(pad_pd_o), 16'h00FF);
    check("p5_state", 16'(dbg_probe_state), 16'h0002);
    cfg_write(3'd5, 5'b11110);               // P6: ie=1, ste=11, pull=up
    check("p6_pd",  16'(pad_pd_o), 16'h00FF);
    check("p6_ie",  16'(pad_ie_o), 16'h00FF);
    check("p6_ste", pad_ste_o,     16'h0000);
    repeat (3) tick();                       // P7..P9
    check("p9_done",  16'(probe_done), 16'h0000);
    check("p9_float", 16'(float_o),    16'h0000);
    tick();                                  // P10: restore
    check("p10_done",  16'(probe_done), 16'h0001);
    check("p10_float", 16'(float_o),    16'h0001);
    check("p10_busy",  16'(probe_busy), 16'h0001);
    check("p10_ie",    16'(pad_ie_o),   16'h0028);
    check("p10_pu",    16'(pad_pu_o),   16'h0028);
    check("p10_pd",    16'(pad_pd_o),   16'h00D7);
    check("p10_ste",   pad_ste_o,       16'h0C00);
    check("p10_state", 16'(dbg_probe_state), 16'h0003);
    pad_ext = 8'h0A;                         // pad 3 now driven high
    tick();                                  // P11
    rise_cnt = 0;
    check("p11_busy",   16'(probe_busy), 16'h0000);
    check("p11_done",   16'(probe_done), 16'h0000);
    check("p11_float",  16'(float_o),    16'h0001);
    check("busy_cycles", 16'(busy_cnt),  16'd11);
    check("done_pulses", 16'(done_cnt),  16'd1);
    check("p11_state",  16'(dbg_probe_state), 16'h0000);
    repeat (3) tick();                       // P12..P14
    check("p14_valid", 16'(din_valid_o), 16'h0000);
    tick();                                  // P15
    check("p15_valid", 16'(din_valid_o), 16'h0028);
    check("p15_din",   16'(din_o),       16'h0008);
    tick();
    check("p15_no_rise", 16'(rise_cnt), 16'h0000);

    // ---------------- ie 1->0 clears din/valid ----------------
    cfg_write(3'd3, 5'b00001);
    check("dis_din",   16'(din_o),       16'h0000);
    check("dis_valid", 16'(din_valid_o), 16'h0020);
    check("dis_ie",    16'(pad_ie_o),    16'h0020);
    check("dis_pu",    16'(pad_pu_o),    16'h0020);
    check("dis_pd",    16'(pad_pd_o),    16'h00DF);

    // ---------------- reset during PU phase ----------------
    probe_start = 1'b1;
    tick();
    probe_start = 1'b0;
    tick();
    tick();
    check("pre_rst_state", 16'(dbg_probe_state), 16'h0001);
    check("pre_rst_float", 16'(float_o), 16'h0001);
    rst = 1'b1;
    #1;
    check("arst_pd",    16'(pad_pd_o),   16'h00FF);
    check("arst_ie",    16'(pad_ie_o),   16'h0000);
    check("arst_pu",    16'(pad_pu_o),   16'h0000);
    check("arst_busy",  16'(probe_busy), 16'h0000);
    check("arst_float", 16'(float_o),    16'h0000);
    check("arst_valid", 16'(din_valid_o), 16'h0000);
    check("arst_state", 16'(dbg_probe_state), 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_state", 16'(dbg_probe_state), 16'h0000);
    check("post_rst_busy",  16'(probe_busy), 16'h0000);
    done_cnt = 0;
    probe_start = 1'b1;
    tick();                                  // P0
    probe_start = 1'b0;
    check("reprobe_busy", 16'(probe_busy), 16'h0001);
    repeat (10) tick();                      // P10
    check("reprobe_done",  16'(probe_done), 16'h0001);
    check("reprobe_float", 16'(float_o),    16'h0001);
    tick();
    check("reprobe_idle",  16'(probe_busy), 16'h0000);
    check("reprobe_pulses", 16'(done_cnt),  16'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
